// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-select and state definitions for the hardwired control sequencer.
package ctrl_pkg;

  localparam logic [4:0] OpAdd  = 5'b00000;
  localparam logic [4:0] OpSub  = 5'b00001;
  localparam logic [4:0] OpAnd  = 5'b00010;
  localparam logic [4:0] OpOr   = 5'b00011;
  localparam logic [4:0] OpLdi  = 5'b00100;
  localparam logic [4:0] OpAddi = 5'b00101;
  localparam logic [4:0] OpBr   = 5'b00110;
  localparam logic [4:0] OpJr   = 5'b00111;
  localparam logic [4:0] OpJal  = 5'b01000;
  localparam logic [4:0] OpIn   = 5'b01001;
  localparam logic [4:0] OpOut  = 5'b01010;
  localparam logic [4:0] OpNop  = 5'b01011;
  localparam logic [4:0] OpHalt = 5'b01100;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3
  } alu_op_e;

  typedef enum logic [3:0] {
    StInit, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
  } state_e;

  typedef struct packed {
    logic    pc_out;
    logic    zlo_out;
    logic    mdr_out;
    logic    mar_enable;
    logic    z_enable;
    logic    pc_enable;
    logic    mdr_enable;
    logic    read;
    logic    ir_enable;
    logic    y_enable;
    logic    pc_increment;
    logic    c_sign_extended_out;
    logic    con_enable;
    logic    r_in;
    logic    r_out;
    logic    gra;
    logic    grb;
    logic    grc;
    logic    ba_out;
    logic    inport_out;
    logic    outport_enable;
    logic    pc_init_enable;
    alu_op_e alu_op;
  } ctrl_word_t;

  function automatic state_e next_step(state_e s);
    state_e n;
    case (s)
      StT0:    n = StT1;
      StT1:    n = StT2;
      StT2:    n = StT3;
      StT3:    n = StT4;
      StT4:    n = StT5;
      StT5:    n = StT6;
      default: n = StT0;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] step_of(state_e s);
    logic [2:0] t;
    case (s)
      StT1:    t = 3'd1;
      StT2:    t = 3'd2;
      StT3:    t = 3'd3;
      StT4:    t = 3'd4;
      StT5:    t = 3'd5;
      StT6:    t = 3'd6;
      default: t = 3'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decode: (state, opcode, con_ff) -> control word, last-step flag
// and an undefined-opcode flag that is meaningful in T2.
module ctrl_decode import ctrl_pkg::*; #(
  parameter int unsigned OP_W = 5
) (
  input  state_e          state,
  input  logic [OP_W-1:0] op,
  input  logic            con_ff,
  output ctrl_word_t      cw,
  output logic            last,
  output logic            undef
);

  always_comb begin
    cw        = '0;
    cw.alu_op = AluAdd;
    last      = 1'b0;
    undef     = 1'b0;
    unique case (state)
      StInit: cw.pc_init_enable = 1'b1;
      StT0: begin
        cw.pc_out = 1'b1; cw.mar_enable = 1'b1; cw.pc_increment = 1'b1; cw.z_enable = 1'b1;
      end
      StT1: begin
        cw.read = 1'b1; cw.mdr_enable = 1'b1; cw.zlo_out = 1'b1; cw.pc_enable = 1'b1;
      end
      StT2: begin
        cw.mdr_out   = 1'b1;
        cw.ir_enable = 1'b1;
        case (op)
          OP_W'(OpAdd), OP_W'(OpSub), OP_W'(OpAnd), OP_W'(OpOr), OP_W'(OpLdi), OP_W'(OpAddi),
          OP_W'(OpBr), OP_W'(OpJr), OP_W'(OpJal), OP_W'(OpIn), OP_W'(OpOut): last = 1'b0;
          OP_W'(OpNop), OP_W'(OpHalt): last = 1'b1;
          default: begin
            last  = 1'b1;
            undef = 1'b1;
          end
        endcase
      end
      StT3, StT4, StT5, StT6: begin
        // Any (state, opcode) pair not listed below ends the instruction.
        last = 1'b1;
        case (op)
          OP_W'(OpAdd), OP_W'(OpSub), OP_W'(OpAnd), OP_W'(OpOr): begin
            last = (state == StT5);
            case (state)
              StT3: begin cw.grb = 1'b1; cw.r_out = 1'b1; cw.y_enable = 1'b1; end
              StT4: begin
                cw.grc = 1'b1; cw.r_out = 1'b1; cw.z_enable = 1'b1;
                // Opcode low bits coincide with the ALU select for the register ops.
                cw.alu_op = alu_op_e'({2'b00, op[1:0]});
              end
              StT5: begin cw.zlo_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
              default: ;
            endcase
          end
          OP_W'(OpLdi), OP_W'(OpAddi): begin
            last = (state == StT5);
            case (state)
              StT3: begin
                cw.grb = 1'b1; cw.y_enable = 1'b1;
                if (op == OP_W'(OpLdi)) cw.ba_out = 1'b1;
                else                    cw.r_out  = 1'b1;
              end
              StT4: begin cw.c_sign_extended_out = 1'b1; cw.z_enable = 1'b1; end
              StT5: begin cw.zlo_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
              default: ;
            endcase
          end
          OP_W'(OpBr): begin
            last = (state == StT6);
            case (state)
              StT3: begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.con_enable = 1'b1; end
              StT4: begin cw.pc_out = 1'b1; cw.y_enable = 1'b1; end
              StT5: begin cw.c_sign_extended_out = 1'b1; cw.z_enable = 1'b1; end
              StT6: begin cw.zlo_out = 1'b1; cw.pc_enable = con_ff; end
              default: ;
            endcase
          end
          OP_W'(OpJr): begin
            if (state == StT3) begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.pc_enable = 1'b1; end
          end
          OP_W'(OpJal): begin
            last = (state == StT4);
            case (state)
              StT3: begin cw.pc_out = 1'b1; cw.grb = 1'b1; cw.r_in = 1'b1; end
              StT4: begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.pc_enable = 1'b1; end
              default: ;
            endcase
          end
          OP_W'(OpIn): begin
            if (state == StT3) begin cw.inport_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
          end
          OP_W'(OpOut): begin
            if (state == StT3) begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.outport_enable = 1'b1; end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired T-step control sequencer: INIT, fetch (T0-T2), opcode-dependent execute (T3-T6),
// HALT. Each step is held for STEP_CYCLES clocks.
module ctrl_sequencer import ctrl_pkg::*; #(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned OP_W        = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        pc_out,
  output logic        zlo_out,
  output logic        mdr_out,
  output logic        mar_enable,
  output logic        z_enable,
  output logic        pc_enable,
  output logic        mdr_enable,
  output logic        read,
  output logic        ir_enable,
  output logic        y_enable,
  output logic        pc_increment,
  output logic        c_sign_extended_out,
  output logic        con_enable,
  output logic        r_in,
  output logic        r_out,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        ba_out,
  output logic        inport_out,
  output logic        outport_enable,
  output logic        pc_init_enable,
  output logic [31:0] pc_init,
  output logic [3:0]  alu_op,
  output logic [2:0]  step,
  output logic        halted,
  output logic        illegal
);

  localparam logic [1:0] CntReload = 2'(STEP_CYCLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [OP_W-1:0] op_q, op_d, ir_op, dec_op;
  logic            illegal_q, illegal_d;
  logic            step_done;
  ctrl_word_t      dec_cw, cw;
  logic            dec_last, dec_undef;
  logic            unused_ir;

  assign ir_op     = ir[31:32-OP_W];
  assign unused_ir = ^ir[31-OP_W:0];
  // T2's control word is opcode-independent; only its exit decision looks at the incoming opcode.
  assign dec_op    = (state_q == StT2) ? ir_op : op_q;

  ctrl_decode #(
    .OP_W(OP_W)
  ) u_decode (
    .state (state_q),
    .op    (dec_op),
    .con_ff(con_ff),
    .cw    (dec_cw),
    .last  (dec_last),
    .undef (dec_undef)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    illegal_d = 1'b0;
    step_done = (cnt_q == 2'd0);
    if (state_q != StHalt) begin
      if (step_done) begin
        cnt_d = CntReload;
        if (state_q == StT2) begin
          op_d      = ir_op;
          illegal_d = dec_undef;
        end
        if (dec_last) state_d = (stop || op_d == OP_W'(OpHalt)) ? StHalt : StT0;
        else          state_d = next_step(state_q);
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= StInit;
      cnt_q     <= CntReload;
      op_q      <= OP_W'(OpNop);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    cw = dec_cw;
    if (clr) begin
      cw        = '0;
      cw.alu_op = AluAdd;
    end
  end

  assign pc_out              = cw.pc_out;
  assign zlo_out             = cw.zlo_out;
  assign mdr_out             = cw.mdr_out;
  assign mar_enable          = cw.mar_enable;
  assign z_enable            = cw.z_enable;
  assign pc_enable           = cw.pc_enable;
  assign mdr_enable          = cw.mdr_enable;
  assign read                = cw.read;
  assign ir_enable           = cw.ir_enable;
  assign y_enable            = cw.y_enable;
  assign pc_increment        = cw.pc_increment;
  assign c_sign_extended_out = cw.c_sign_extended_out;
  assign con_enable          = cw.con_enable;
  assign r_in                = cw.r_in;
  assign r_out               = cw.r_out;
  assign gra                 = cw.gra;
  assign grb                 = cw.grb;
  assign grc                 = cw.grc;
  assign ba_out              = cw.ba_out;
  assign inport_out          = cw.inport_out;
  assign outport_enable      = cw.outport_enable;
  assign pc_init_enable      = cw.pc_init_enable;
  assign alu_op              = cw.alu_op;
  assign pc_init             = PC_RESET;
  assign step                = clr ? 3'd0 : step_of(state_q);
  assign halted              = !clr && (state_q == StHalt);
  assign illegal             = !clr && illegal_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed scenarios plus a random instruction stream, each clock
// compared against a per-opcode step table.
module tb_ctrl_sequencer;

  localparam logic [31:0] PcReset = 32'hDEAD_BEE0;
  localparam int unsigned Sc      = 2;

  localparam logic [4:0] OpAdd = 5'd0,  OpSub = 5'd1, OpAnd = 5'd2,  OpOr = 5'd3, OpLdi = 5'd4;
  localparam logic [4:0] OpAddi = 5'd5, OpBr = 5'd6,  OpJr = 5'd7,   OpJal = 5'd8, OpIn = 5'd9;
  localparam logic [4:0] OpOut = 5'd10, OpNop = 5'd11, OpHalt = 5'd12;

  localparam logic [21:0] MPcOut = 22'd1 << 21, MZloOut = 22'd1 << 20, MMdrOut = 22'd1 << 19;
  localparam logic [21:0] MMarEn = 22'd1 << 18, MZEn = 22'd1 << 17,    MPcEn = 22'd1 << 16;
  localparam logic [21:0] MMdrEn = 22'd1 << 15, MRead = 22'd1 << 14,   MIrEn = 22'd1 << 13;
  localparam logic [21:0] MYEn = 22'd1 << 12,   MPcInc = 22'd1 << 11,  MCse = 22'd1 << 10;
  localparam logic [21:0] MConEn = 22'd1 << 9,  MRIn = 22'd1 << 8,     MROut = 22'd1 << 7;
  localparam logic [21:0] MGra = 22'd1 << 6,    MGrb = 22'd1 << 5,     MGrc = 22'd1 << 4;
  localparam logic [21:0] MBaOut = 22'd1 << 3,  MInp = 22'd1 << 2,     MOutp = 22'd1 << 1;
  localparam logic [21:0] MPcInitEn = 22'd1;

  logic clk, clr, con_ff, stop;
  logic [31:0] ir, pc_init;
  logic [3:0] alu_op;
  logic [2:0] step;
  logic halted, illegal;
  logic pc_out, zlo_out, mdr_out, mar_enable, z_enable, pc_enable, mdr_enable, read, ir_enable;
  logic y_enable, pc_increment, c_sign_extended_out, con_enable, r_in, r_out, gra, grb, grc;
  logic ba_out, inport_out, outport_enable, pc_init_enable;
  logic [21:0] obs_cw;

  assign obs_cw = {pc_out, zlo_out, mdr_out, mar_enable, z_enable, pc_enable, mdr_enable, read,
                   ir_enable, y_enable, pc_increment, c_sign_extended_out, con_enable, r_in,
                   r_out, gra, grb, grc, ba_out, inport_out, outport_enable, pc_init_enable};

  ctrl_sequencer #(
    .PC_RESET   (PcReset),
    .STEP_CYCLES(Sc),
    .OP_W       (5)
  ) dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
    .pc_out(pc_out), .zlo_out(zlo_out), .mdr_out(mdr_out), .mar_enable(mar_enable),
    .z_enable(z_enable), .pc_enable(pc_enable), .mdr_enable(mdr_enable), .read(read),
    .ir_enable(ir_enable), .y_enable(y_enable), .pc_increment(pc_increment),
    .c_sign_extended_out(c_sign_extended_out), .con_enable(con_enable), .r_in(r_in),
    .r_out(r_out), .gra(gra), .grb(grb), .grc(grc), .ba_out(ba_out), .inport_out(inport_out),
    .outport_enable(outport_enable), .pc_init_enable(pc_init_enable), .pc_init(pc_init),
    .alu_op(alu_op), .step(step), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [21:0] exp_cw [7];
  logic [3:0]  exp_alu [7];
  bit pend_illegal;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_cycle(input string w, input logic [2:0] st, input logic [21:0] cw_e,
                           input logic [3:0] alu_e, input logic hl, input logic il);
    chk({w, " cw"}, 32'(obs_cw), 32'(cw_e));
    chk({w, " alu_op"}, 32'(alu_op), 32'(alu_e));
    chk({w, " step"}, 32'(step), 32'(st));
    chk({w, " halted"}, 32'(halted), 32'(hl));
    chk({w, " illegal"}, 32'(illegal), 32'(il));
    chk({w, " pc_init"}, pc_init, PcReset);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step table per opcode: expected control word and ALU select for each T index.
  task automatic build_model(input logic [4:0] op, input bit cf, output int n);
    for (int i = 0; i < 7; i++) begin
      exp_cw[i]  = '0;
      exp_alu[i] = 4'd0;
    end
    exp_cw[0] = MPcOut | MMarEn | MPcInc | MZEn;
    exp_cw[1] = MRead | MMdrEn | MZloOut | MPcEn;
    exp_cw[2] = MMdrOut | MIrEn;
    n = 3;
    case (op)
      OpAdd, OpSub, OpAnd, OpOr: begin
        exp_cw[3] = MGrb | MROut | MYEn;
        exp_cw[4] = MGrc | MROut | MZEn;
        exp_alu[4] = {2'b00, op[1:0]};
        exp_cw[5] = MZloOut | MGra | MRIn;
        n = 6;
      end
      OpLdi, OpAddi: begin
        exp_cw[3] = MGrb | MYEn | ((op == OpLdi) ? MBaOut : MROut);
        exp_cw[4] = MCse | MZEn;
        exp_cw[5] = MZloOut | MGra | MRIn;
        n = 6;
      end
      OpBr: begin
        exp_cw[3] = MGra | MROut | MConEn;
        exp_cw[4] = MPcOut | MYEn;
        exp_cw[5] = MCse | MZEn;
        exp_cw[6] = MZloOut | (cf ? MPcEn : 22'd0);
        n = 7;
      end
      OpJr:  begin exp_cw[3] = MGra | MROut | MPcEn; n = 4; end
      OpJal: begin exp_cw[3] = MPcOut | MGrb | MRIn; exp_cw[4] = MGra | MROut | MPcEn; n = 5; end
      OpIn:  begin exp_cw[3] = MInp | MGra | MRIn; n = 4; end
      OpOut: begin exp_cw[3] = MGra | MROut | MOutp; n = 4; end
      default: n = 3;
    endcase
  endtask

  task automatic do_reset(input string why);
    clr = 1'b1;
    #1;
    chk_cycle({why, " clr-comb"}, 3'd0, 22'd0, 4'd0, 1'b0, 1'b0);
    tick();
    chk_cycle({why, " clr-held"}, 3'd0, 22'd0, 4'd0, 1'b0, 1'b0);
    clr = 1'b0;
    #1;
    for (int c = 0; c < Sc; c++) begin
      chk_cycle($sformatf("%s INIT c%0d", why, c), 3'd0, MPcInitEn, 4'd0, 1'b0, 1'b0);
      tick();
    end
    pend_illegal = 1'b0;
  endtask

  // Precondition: the DUT is in the first clock of T0.
  task automatic run_instr(input logic [4:0] op, input bit cf, input int stop_at,
                           input int clr_at, output bit went_halt);
    int n;
    string w;
    build_model(op, cf, n);
    ir        = {op, 27'($urandom)};
    con_ff    = cf;
    went_halt = 1'b0;
    for (int t = 0; t < n; t++) begin
      for (int c = 0; c < Sc; c++) begin
        w = $sformatf("op%0d cf%0d T%0d c%0d", op, cf, t, c);
        chk_cycle(w, 3'(t), exp_cw[t], exp_alu[t], 1'b0,
                  (t == 0 && c == 0) ? pend_illegal : 1'b0);
        if (t == clr_at && c == 0) begin
          do_reset($sformatf("op%0d clr@T%0d", op, t));
          return;
        end
        if (t == stop_at && c == 0) stop = 1'b1;
        tick();
      end
    end
    pend_illegal = (op > OpHalt);
    went_halt    = (stop_at >= 0) || (op == OpHalt);
  endtask

  task automatic check_halt(input string why, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      chk_cycle($sformatf("%s HALT c%0d", why, c), 3'd0, 22'd0, 4'd0, 1'b1,
                (c == 0) ? pend_illegal : 1'b0);
      tick();
    end
    pend_illegal = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit h;
    logic [4:0] rop;
    clr = 1'b1; ir = '0; con_ff = 1'b0; stop = 1'b0; pend_illegal = 1'b0;
    do_reset("power-up");

    run_instr(OpLdi, 1'b0, -1, -1, h);
    run_instr(OpJr, 1'b1, -1, -1, h);
    run_instr(OpBr, 1'b0, -1, -1, h);
    run_instr(OpBr, 1'b1, -1, -1, h);
    run_instr(5'b11111, 1'b0, -1, -1, h);
    run_instr(OpNop, 1'b0, -1, -1, h);
    run_instr(OpIn, 1'b0, -1, -1, h);
    run_instr(OpOut, 1'b1, -1, -1, h);
    run_instr(OpJal, 1'b0, -1, -1, h);
    run_instr(OpAddi, 1'b0, -1, -1, h);
    run_instr(OpSub, 1'b1, -1, -1, h);
    run_instr(OpAnd, 1'b0, -1, -1, h);
    run_instr(OpOr, 1'b0, -1, -1, h);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) rop = 5'($urandom_range(13, 31));
      else                           rop = 5'($urandom_range(0, 11));
      run_instr(rop, 1'($urandom_range(0, 1)), -1, -1, h);
    end

    run_instr(OpAdd, 1'b0, 4, -1, h);
    if (h) check_halt("stop", 10);
    stop = 1'b0;
    do_reset("from-halt");

    run_instr(OpJal, 1'b0, -1, 3, h);
    run_instr(OpAdd, 1'b1, -1, -1, h);
    run_instr(OpHalt, 1'b0, -1, -1, h);
    if (h) check_halt("halt-op", 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
